uart_protocol_rx: RTL



---
 rtl/uart_protocol_rx.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/uart_protocol_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_protocol_rx
// Brief    : Request-frame parser (HEAD, payload, CRC-8, TAIL) feeding the
//            response transmitter. Optional RX_FRAME_CNT_EN adds frame counters.
// Revision : 1.0 - initial release
// ============================================================================
module uart_protocol_rx #(
  parameter logic [7:0]  _HEAD_BYTE = 8'hAA,
  parameter logic [7:0]  _TAIL_BYTE = 8'h55,
  parameter int          _DATA_LEN  = 11,
  parameter logic [15:0] _TIMEOUT   = 16'd10000
) (
  input  logic        clk_50M,
  input  logic        rst,
  input  logic        uart_rx_done,
  input  logic [7:0]  uart_rx_data,
  output logic [7:0]  rev_data0,
  output logic [7:0]  rev_data1,
  output logic [7:0]  rev_data2,
  output logic [7:0]  rev_data3,
  output logic [7:0]  rev_data4,
  output logic [7:0]  rev_data5,
  output logic [7:0]  rev_data6,
  output logic [7:0]  rev_data7,
  output logic [7:0]  rev_data8,
  output logic [7:0]  rev_data9,
  output logic [7:0]  rev_data10,
  output logic        recv_done,
  output logic        recv_err,
  output logic [7:0]  response_data
`ifdef RX_FRAME_CNT_EN
  ,
  output logic [15:0] good_frame_cnt,
  output logic [15:0] err_frame_cnt
`endif
);

  localparam logic [3:0]  c_last_idx = 4'(_DATA_LEN - 1);
  localparam logic [15:0] c_tmo_last = _TIMEOUT - 16'd1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_CRCK = 2'd2,
    S_TAIL = 2'd3
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [7:0]  r_crc;
  logic        r_crc_ok;
  logic [15:0] r_idle;
  logic [7:0]  r_shadow [0:10];
  logic [7:0]  r_rev    [0:10];
  logic        r_done;
  logic        r_err;
  logic [7:0]  r_resp;
  logic        w_timeout;

  // CRC-8, poly 0x07, MSB first, one byte per call
  function automatic logic [7:0] f_crc8(input logic [7:0] crc, input logic [7:0] din);
    logic [7:0] c;
    c = crc ^ din;
    for (int b = 0; b < 8; b++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  // A byte arriving on the expiry cycle takes priority over the timeout
  assign w_timeout = (r_state != S_IDLE) && !uart_rx_done && (r_idle == c_tmo_last);

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_crc    <= 8'h00;
      r_crc_ok <= 1'b0;
      r_idle   <= 16'd0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_resp   <= 8'h00;
      for (int i = 0; i < 11; i++) begin
        r_shadow[i] <= 8'h00;
        r_rev[i]    <= 8'h00;
      end
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (r_state == S_IDLE || uart_rx_done) r_idle <= 16'd0;
      else                                  r_idle <= r_idle + 16'd1;

      if (w_timeout) begin
        r_state <= S_IDLE;
        r_err   <= 1'b1;
        r_resp  <= 8'h03;
      end else if (uart_rx_done) begin
        case (r_state)
          S_IDLE: begin
            if (uart_rx_data == _HEAD_BYTE) begin
              r_state <= S_DATA;
              r_cnt   <= 4'd0;
              r_crc   <= 8'h00;
            end
          end
          S_DATA: begin
            r_shadow[r_cnt] <= uart_rx_data;
            r_crc           <= f_crc8(r_crc, uart_rx_data);
            r_cnt           <= r_cnt + 4'd1;
            if (r_cnt == c_last_idx) r_state <= S_CRCK;
          end
          S_CRCK: begin
            r_crc_ok <= (uart_rx_data == r_crc);
            r_state  <= S_TAIL;
          end
          S_TAIL: begin
            r_state <= S_IDLE;
            if (uart_rx_data != _TAIL_BYTE) begin
              r_err  <= 1'b1;
              r_resp <= 8'h02;
            end else if (!r_crc_ok) begin
              r_err  <= 1'b1;
              r_resp <= 8'h01;
            end else begin
              r_done <= 1'b1;
              r_resp <= 8'h00;
              for (int i = 0; i < 11; i++) r_rev[i] <= r_shadow[i];
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign rev_data0     = r_rev[0];
  assign rev_data1     = r_rev[1];
  assign rev_data2     = r_rev[2];
  assign rev_data3     = r_rev[3];
  assign rev_data4     = r_rev[4];
  assign rev_data5     = r_rev[5];
  assign rev_data6     = r_rev[6];
  assign rev_data7     = r_rev[7];
  assign rev_data8     = r_rev[8];
  assign rev_data9     = r_rev[9];
  assign rev_data10    = r_rev[10];
  assign recv_done     = r_done;
  assign recv_err      = r_err;
  assign response_data = r_resp;

`ifdef RX_FRAME_CNT_EN
  logic [15:0] r_good_cnt;
  logic [15:0] r_err_cnt;

  // Saturating counters track the registered pulses, so they lag them by one cycle
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      r_good_cnt <= 16'd0;
      r_err_cnt  <= 16'd0;
    end else begin
      if (r_done && r_good_cnt != 16'hFFFF) r_good_cnt <= r_good_cnt + 16'd1;
      if (r_err  && r_err_cnt  != 16'hFFFF) r_err_cnt  <= r_err_cnt + 16'd1;
    end
  end

  assign good_frame_cnt = r_good_cnt;
  assign err_frame_cnt  = r_err_cnt;
`endif

endmodule
`default_nettype wire
